// File: rtl/memory_mapper_ctx.sv
// Multi-context page mapper: translates CPU page MA through one of CONTEXTS byte-programmable tables.
// Define MM_WP_EN to compile in per-entry write protect (entry bit15) with a sticky, write-1-to-clear fault flag.
module memory_mapper_ctx #(
  parameter int PAGE_BITS = 4,
  parameter int OUT_BITS  = 12,
  parameter int CONTEXTS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 MM_cs,
  input  logic                 rw,
  input  logic [PAGE_BITS:0]   RS,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [PAGE_BITS-1:0] MA,
  input  logic                 cpu_we,
  output logic [OUT_BITS-1:0]  MO,
  output logic                 fault
);

  localparam int ENTRIES = 1 << PAGE_BITS;
  localparam int CTX_W   = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;
  localparam logic [1:0]  CTX_MAX  = 2'(CONTEXTS - 1);
  localparam logic [15:0] VAL_MASK = 16'((32'd1 << OUT_BITS) - 1);
`ifdef MM_WP_EN
  localparam logic [15:0] ENTRY_MASK = VAL_MASK | 16'h8000;
`else
  localparam logic [15:0] ENTRY_MASK = VAL_MASK;
`endif

  logic [15:0] tbl_q [1 << CTX_W][ENTRIES];

  logic       en_q, en_d;
  logic [1:0] actx_q, actx_d;
  logic [1:0] ectx_q, ectx_d;
  logic       fault_q, fault_d;

  logic                 tbl_we;
  logic [PAGE_BITS-1:0] rs_idx;
  logic [15:0]          edit_entry, act_entry, entry_d;
  logic [7:0]           ctrl_rd;
  logic                 unused_ok;

  function automatic logic [1:0] clamp_ctx(input logic [1:0] v);
    return (v > CTX_MAX) ? CTX_MAX : v;
  endfunction

  assign rs_idx     = RS[PAGE_BITS:1];
  assign edit_entry = tbl_q[ectx_q[CTX_W-1:0]][rs_idx];
  assign act_entry  = tbl_q[actx_q[CTX_W-1:0]][MA];
  assign unused_ok  = ^{act_entry, cpu_we};

  // Byte merge into the edit-context entry; unimplemented bits are never stored.
  always_comb begin
    tbl_we  = cs && !rw && !rst;
    entry_d = edit_entry;
    if (RS[0]) entry_d[15:8] = data_in;
    else       entry_d[7:0]  = data_in;
    entry_d = entry_d & ENTRY_MASK;
  end

  always_comb begin
    en_d   = en_q;
    actx_d = actx_q;
    ectx_d = ectx_q;
    if (MM_cs && !rw) begin
      en_d   = data_in[0];
      actx_d = clamp_ctx(data_in[2:1]);
      ectx_d = clamp_ctx(data_in[4:3]);
    end
`ifdef MM_WP_EN
    // Set wins over a same-cycle clear, so the clear is applied first.
    fault_d = fault_q;
    if (MM_cs && !rw && data_in[7]) fault_d = 1'b0;
    if (en_q && cpu_we && act_entry[15]) fault_d = 1'b1;
`else
    fault_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      actx_q  <= '0;
      ectx_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      en_q    <= en_d;
      actx_q  <= actx_d;
      ectx_q  <= ectx_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the table is deliberately not reset; tbl_we already drops writes coinciding with rst.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[ectx_q[CTX_W-1:0]][rs_idx] <= entry_d;
  end

  assign ctrl_rd = {fault_q, 2'b00, ectx_q, actx_q, en_q};

  // NOTE: data_out gets a default first so the read mux cannot infer a latch.
  always_comb begin
    data_out = 8'h00;
    if (rw) begin
      if (cs)         data_out = RS[0] ? edit_entry[15:8] : edit_entry[7:0];
      else if (MM_cs) data_out = ctrl_rd;
    end
  end

  assign MO    = en_q ? act_entry[OUT_BITS-1:0] : '0;
  assign fault = fault_q;

endmodule

// File: tb/tb_memory_mapper_ctx.sv
// Directed bench for memory_mapper_ctx at default parameters; expectations follow MM_WP_EN when defined.
module tb_memory_mapper_ctx;

  logic        clk = 1'b0;
  logic        rst, cs, MM_cs, rw, cpu_we;
  logic [4:0]  RS;
  logic [7:0]  data_in, data_out;
  logic [3:0]  MA;
  logic [11:0] MO;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  memory_mapper_ctx #(.PAGE_BITS(4), .OUT_BITS(12), .CONTEXTS(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .MM_cs(MM_cs), .rw(rw), .RS(RS),
    .data_in(data_in), .data_out(data_out), .MA(MA), .cpu_we(cpu_we),
    .MO(MO), .fault(fault)
  );

  always #5 clk = ~clk;

`ifdef MM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tbl(input logic [4:0] rs, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; RS = rs; data_in = d;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    MM_cs = 1'b1; rw = 1'b0; data_in = d;
    tick();
    MM_cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_tbl(input logic [4:0] rs, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; RS = rs;
    #1 d = data_out;
    cs = 1'b0;
    #1;
  endtask

  task automatic rd_ctrl(output logic [7:0] d);
    MM_cs = 1'b1; rw = 1'b1;
    #1 d = data_out;
    MM_cs = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    rst = 1'b1; cs = 1'b0; MM_cs = 1'b0; rw = 1'b1; cpu_we = 1'b0;
    RS = '0; data_in = '0; MA = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (MO !== 12'h000) begin n_err++; $display("FAIL reset_mo: got %h expected %h", MO, 12'h000); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected %b", fault, 1'b0); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h expected %h", data_out, 8'h00); end
    rd_ctrl(got);
    n_cmp++; if (got !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", got, 8'h00); end
  endtask

  task automatic test_enable;
    logic [7:0] got;
    wr_tbl(5'h00, 8'hCC);
    wr_tbl(5'h01, 8'h00);
    MA = 4'd0; #1;
    n_cmp++; if (MO !== 12'h000) begin n_err++; $display("FAIL en_off_mo: got %h expected %h", MO, 12'h000); end
    wr_ctrl(8'h01);
    n_cmp++; if (MO !== 12'h0CC) begin n_err++; $display("FAIL en_on_mo: got %h expected %h", MO, 12'h0CC); end
    rd_tbl(5'h00, got);
    n_cmp++; if (got !== 8'hCC) begin n_err++; $display("FAIL rd_lo_0: got %h expected %h", got, 8'hCC); end
    wr_ctrl(8'h00);
    n_cmp++; if (MO !== 12'h000) begin n_err++; $display("FAIL en_clr_mo: got %h expected %h", MO, 12'h000); end
  endtask

  task automatic test_inactive_ctx;
    logic [7:0] got;
    wr_tbl(5'h0A, 8'h23);
    wr_tbl(5'h0B, 8'h01);
    wr_ctrl(8'h09);
    rd_ctrl(got);
    n_cmp++; if (got !== 8'h09) begin n_err++; $display("FAIL ctrl_rd_09: got %h expected %h", got, 8'h09); end
    MA = 4'd5; #1;
    n_cmp++; if (MO !== 12'h123) begin n_err++; $display("FAIL ctx0_mo: got %h expected %h", MO, 12'h123); end
    wr_tbl(5'h0A, 8'hBC);
    wr_tbl(5'h0B, 8'h0A);
    n_cmp++; if (MO !== 12'h123) begin n_err++; $display("FAIL inactive_edit_mo: got %h expected %h", MO, 12'h123); end
    wr_ctrl(8'h03);
    n_cmp++; if (MO !== 12'hABC) begin n_err++; $display("FAIL ctx1_mo: got %h expected %h", MO, 12'hABC); end
  endtask

  task automatic test_mask;
    logic [7:0] got, exp;
    exp = WP ? 8'h8F : 8'h0F;
    wr_tbl(5'h03, 8'hFF);
    rd_tbl(5'h03, got);
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mask_hi: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    wr_ctrl(8'h09);
    wr_tbl(5'h02, 8'h77);
    wr_ctrl(8'h01);
    // One shared data bus: both selects see 0x19 on the same edge.
    cs = 1'b1; MM_cs = 1'b1; rw = 1'b0; RS = 5'h02; data_in = 8'h19;
    tick();
    cs = 1'b0; MM_cs = 1'b0; rw = 1'b1;
    rd_ctrl(got);
    n_cmp++; if (got !== 8'h09) begin n_err++; $display("FAIL dual_ctrl_clamp: got %h expected %h", got, 8'h09); end
    rd_tbl(5'h02, got);
    n_cmp++; if (got !== 8'h77) begin n_err++; $display("FAIL dual_ctx1_kept: got %h expected %h", got, 8'h77); end
    MA = 4'd1; #1;
    n_cmp++; if (MO !== 12'hF19) begin n_err++; $display("FAIL dual_ctx0_mo: got %h expected %h", MO, 12'hF19); end
    wr_ctrl(8'h01);
    rd_tbl(5'h02, got);
    n_cmp++; if (got !== 8'h19) begin n_err++; $display("FAIL dual_ctx0_lo: got %h expected %h", got, 8'h19); end
    wr_ctrl(8'h07);
    rd_ctrl(got);
    n_cmp++; if (got !== 8'h03) begin n_err++; $display("FAIL actx_clamp: got %h expected %h", got, 8'h03); end
  endtask

  task automatic test_write_protect;
    logic [7:0] got, exp_c;
    logic       exp_f;
    exp_f = WP;
    exp_c = WP ? 8'h81 : 8'h01;
    wr_ctrl(8'h01);
    wr_tbl(5'h04, 8'h00);
    wr_tbl(5'h05, 8'h80);
    MA = 4'd2; #1;
    n_cmp++; if (MO !== 12'h000) begin n_err++; $display("FAIL wp_mo: got %h expected %h", MO, 12'h000); end
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    n_cmp++; if (fault !== exp_f) begin n_err++; $display("FAIL wp_set: got %b expected %b", fault, exp_f); end
    tick(); tick();
    n_cmp++; if (fault !== exp_f) begin n_err++; $display("FAIL wp_sticky: got %b expected %b", fault, exp_f); end
    rd_ctrl(got);
    n_cmp++; if (got !== exp_c) begin n_err++; $display("FAIL wp_ctrl_rd: got %h expected %h", got, exp_c); end
    wr_ctrl(8'h81);
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL wp_clear: got %b expected %b", fault, 1'b0); end
    cpu_we = 1'b1;
    wr_ctrl(8'h81);
    cpu_we = 1'b0;
    n_cmp++; if (fault !== exp_f) begin n_err++; $display("FAIL wp_set_wins: got %b expected %b", fault, exp_f); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] got;
    MA = 4'd0; #1;
    n_cmp++; if (MO !== 12'h0CC) begin n_err++; $display("FAIL pre_rst_mo: got %h expected %h", MO, 12'h0CC); end
    rst = 1'b1; cs = 1'b1; MM_cs = 1'b1; rw = 1'b0; RS = 5'h00; data_in = 8'hEE;
    tick();
    rst = 1'b0; cs = 1'b0; MM_cs = 1'b0; rw = 1'b1;
    #1;
    n_cmp++; if (MO !== 12'h000) begin n_err++; $display("FAIL rst_mid_mo: got %h expected %h", MO, 12'h000); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_mid_fault: got %b expected %b", fault, 1'b0); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_mid_data_out: got %h expected %h", data_out, 8'h00); end
    rd_ctrl(got);
    n_cmp++; if (got !== 8'h00) begin n_err++; $display("FAIL rst_mid_ctrl: got %h expected %h", got, 8'h00); end
    rd_tbl(5'h00, got);
    n_cmp++; if (got !== 8'hCC) begin n_err++; $display("FAIL rst_tbl_lo: got %h expected %h", got, 8'hCC); end
    rd_tbl(5'h01, got);
    n_cmp++; if (got !== 8'h00) begin n_err++; $display("FAIL rst_tbl_hi: got %h expected %h", got, 8'h00); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_inactive_ctx();
    test_mask();
    test_back_to_back();
    test_write_protect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
